// File: rtl/enemy_grid_sprite.sv
// Single-enemy life-cycle FSM and sprite ROM address generator for a grid play field.
// Optional pop-up reveal animation is enabled by defining ENEMY_POPUP_EN.
module enemy_grid_sprite #(
    parameter int unsigned GRID_COLS   = 3,
    parameter int unsigned GRID_ROWS   = 3,
    parameter int unsigned POS_W       = 4,
    parameter int unsigned SPRITE_W    = 160,
    parameter int unsigned SPRITE_H    = 120,
    parameter int unsigned ORIGIN_X    = 40,
    parameter int unsigned ORIGIN_Y    = 50,
    parameter int unsigned PITCH_X     = 170,
    parameter int unsigned PITCH_Y     = 130,
    parameter int unsigned ROW_SHIFT_X = 25,
    parameter int unsigned HIT_FRAMES  = 16,
    parameter int unsigned BLINK_LOG2  = 2,
    parameter int unsigned POPUP_STEP  = 8,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              spawn,
    input  logic [POS_W-1:0]  spawn_pos,
    input  logic              hit,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              draw_en,
    output logic              active,
    output logic [POS_W-1:0]  cur_pos,
    output logic              hit_done
);

    localparam int unsigned N_CELLS = GRID_COLS * GRID_ROWS;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned TIMER_W = ($clog2(HIT_FRAMES) > BLINK_LOG2) ? $clog2(HIT_FRAMES) : BLINK_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, RISE, SHOW, HIT} state_t;

    state_t               state, state_n;
    logic [COORD_W-1:0]   x0_q, x0_n, y0_q, y0_n;
    logic [TIMER_W-1:0]   timer_q, timer_n;
    logic [POS_W-1:0]     pos_n;
    logic                 done_n, draw_n, vis, in_win, pos_valid;
    logic [ADDR_W-1:0]    addr_n;
    logic [COORD_W-1:0]   h_ext, v_ext, dx, dy, row_off, spawn_x0, spawn_y0;
    int unsigned          cell_idx, cell_r, cell_c;
`ifdef ENEMY_POPUP_EN
    localparam int unsigned ROWS_W = $clog2(SPRITE_H + POPUP_STEP + 1);
    logic [ROWS_W-1:0]    rows_q, rows_n;
`endif

    // Cell geometry, only used when a spawn is latched (off the pixel path)
    always_comb begin
        pos_valid = (spawn_pos != '0) && (32'(spawn_pos) <= N_CELLS);
        cell_idx  = pos_valid ? 32'(spawn_pos) - 32'd1 : 32'd0;
        cell_r    = cell_idx / GRID_COLS;
        cell_c    = cell_idx % GRID_COLS;
        spawn_x0  = COORD_W'(ORIGIN_X + cell_r * ROW_SHIFT_X + cell_c * PITCH_X);
        spawn_y0  = COORD_W'(ORIGIN_Y + cell_r * PITCH_Y);
    end

    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign dx     = h_ext - x0_q;
    assign dy     = v_ext - y0_q;
    assign in_win = (h_ext >= x0_q) && (h_ext < x0_q + COORD_W'(SPRITE_W)) &&
                    (v_ext >= y0_q) && (v_ext < y0_q + COORD_W'(SPRITE_H));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        pos_n   = cur_pos;
        x0_n    = x0_q;
        y0_n    = y0_q;
        timer_n = timer_q;
        done_n  = 1'b0;
        vis     = 1'b0;
        row_off = '0;
`ifdef ENEMY_POPUP_EN
        rows_n  = rows_q;
`endif
        case (state)
            IDLE: begin
                if (spawn && pos_valid) begin
                    pos_n   = spawn_pos;
                    x0_n    = spawn_x0;
                    y0_n    = spawn_y0;
                    timer_n = '0;
`ifdef ENEMY_POPUP_EN
                    rows_n  = '0;
                    state_n = RISE;
`else
                    state_n = SHOW;
`endif
                end
            end
`ifdef ENEMY_POPUP_EN
            // Sprite slides up: bottom rows_q rows of the cell show the top of the sprite
            RISE: begin
                row_off = COORD_W'(SPRITE_H) - COORD_W'(rows_q);
                vis     = dy >= row_off;
                if (hit) begin
                    timer_n = '0;
                    state_n = HIT;
                end else if (frame_tick) begin
                    if (32'(rows_q) + POPUP_STEP >= SPRITE_H) begin
                        rows_n  = ROWS_W'(SPRITE_H);
                        state_n = SHOW;
                    end else begin
                        rows_n  = rows_q + ROWS_W'(POPUP_STEP);
                    end
                end
            end
`endif
            SHOW: begin
                vis = 1'b1;
                if (hit) begin
                    timer_n = '0;
                    state_n = HIT;
                end
            end
            HIT: begin
                vis = ~timer_q[BLINK_LOG2];
                if (frame_tick) begin
                    if (32'(timer_q) == HIT_FRAMES - 1) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        pos_n   = '0;
                    end else begin
                        timer_n = timer_q + TIMER_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        draw_n = vis && in_win;
        addr_n = draw_n ? ADDR_W'(32'(dx) + 32'(dy - row_off) * SPRITE_W) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q     <= '0;
            y0_q     <= '0;
            timer_q  <= '0;
            cur_pos  <= '0;
            rom_addr <= '0;
            draw_en  <= 1'b0;
            active   <= 1'b0;
            hit_done <= 1'b0;
`ifdef ENEMY_POPUP_EN
            rows_q   <= '0;
`endif
        end else begin
            x0_q     <= x0_n;
            y0_q     <= y0_n;
            timer_q  <= timer_n;
            cur_pos  <= pos_n;
            rom_addr <= addr_n;
            draw_en  <= draw_n;
            active   <= (state_n != IDLE);
            hit_done <= done_n;
`ifdef ENEMY_POPUP_EN
            rows_q   <= rows_n;
`endif
        end
    end

endmodule

// File: tb/tb_enemy_grid_sprite.sv
// Directed self-checking bench for enemy_grid_sprite (default build, no pop-up).
module tb_enemy_grid_sprite;

    logic        clk = 1'b0;
    logic        rst, frame_tick, spawn, hit;
    logic [3:0]  spawn_pos;
    logic [9:0]  h_cnt, v_cnt;
    logic [14:0] rom_addr;
    logic        draw_en, active, hit_done;
    logic [3:0]  cur_pos;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    enemy_grid_sprite dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .spawn(spawn),
        .spawn_pos(spawn_pos), .hit(hit), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .rom_addr(rom_addr), .draw_en(draw_en), .active(active),
        .cur_pos(cur_pos), .hit_done(hit_done)
    );

    typedef struct {
        logic        rst, spawn, hit, tick;
        logic [3:0]  pos;
        logic [9:0]  h, v;
        logic        e_draw;
        logic [14:0] e_addr;
        logic        e_act;
        logic [3:0]  e_pos;
        logic        e_done;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(int r, int s, int p, int ht, int t, int h, int v,
                                int d, int a, int act, int cp, int dn);
        vec_t x;
        x.rst = 1'(r); x.spawn = 1'(s); x.pos = 4'(p); x.hit = 1'(ht); x.tick = 1'(t);
        x.h = 10'(h); x.v = 10'(v);
        x.e_draw = 1'(d); x.e_addr = 15'(a); x.e_act = 1'(act); x.e_pos = 4'(cp); x.e_done = 1'(dn);
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input int s, input int p, input int ht,
                         input int t, input int h, input int v);
        rst = 1'(r); spawn = 1'(s); spawn_pos = 4'(p); hit = 1'(ht);
        frame_tick = 1'(t); h_cnt = 10'(h); v_cnt = 10'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int d, input int a,
                           input int act, input int cp, input int dn);
        chk({tag, " draw_en"}, int'(draw_en), d);
        chk({tag, " rom_addr"}, int'(rom_addr), a);
        chk({tag, " active"}, int'(active), act);
        chk({tag, " cur_pos"}, int'(cur_pos), cp);
        chk({tag, " hit_done"}, int'(hit_done), dn);
    endtask

    initial begin
        //              rst spn pos hit tck  h    v   | drw addr  act pos done
        vecs[0]  = mk(1, 0, 0, 0, 0,   0,   0,   0, 0,     0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0,  40,  50,   0, 0,     0, 0, 0); // hit in IDLE
        vecs[2]  = mk(0, 1, 0, 0, 0,  40,  50,   0, 0,     0, 0, 0); // pos 0 invalid
        vecs[3]  = mk(0, 1, 10, 0, 0, 40,  50,   0, 0,     0, 0, 0); // pos 10 invalid
        vecs[4]  = mk(0, 1, 5, 0, 1,   0,   0,   0, 0,     1, 5, 0); // spawn + tick
        vecs[5]  = mk(0, 0, 0, 0, 0, 235, 180,   1, 0,     1, 5, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 236, 181,   1, 161,   1, 5, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 395, 200,   0, 0,     1, 5, 0); // x high exclusive
        vecs[8]  = mk(0, 0, 0, 0, 0, 234, 200,   0, 0,     1, 5, 0); // x below
        vecs[9]  = mk(0, 0, 0, 0, 0, 394, 299,   1, 19199, 1, 5, 0); // last pixel
        vecs[10] = mk(0, 0, 0, 0, 0, 394, 300,   0, 0,     1, 5, 0); // y high exclusive
        vecs[11] = mk(0, 1, 2, 0, 0, 235, 180,   1, 0,     1, 5, 0); // no retarget
        vecs[12] = mk(1, 0, 0, 0, 0, 235, 180,   0, 0,     0, 0, 0);
        vecs[13] = mk(0, 1, 9, 0, 0,   0,   0,   0, 0,     1, 9, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 430, 310,   1, 0,     1, 9, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 589, 429,   1, 19199, 1, 9, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 429, 310,   0, 0,     1, 9, 0);
        vecs[17] = mk(1, 0, 0, 0, 0,   0,   0,   0, 0,     0, 0, 0);
        vecs[18] = mk(0, 1, 1, 0, 0,   0,   0,   0, 0,     1, 1, 0);
        vecs[19] = mk(0, 0, 0, 0, 0,  40,  50,   1, 0,     1, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 0,  50,  60,   1, 1610,  1, 1, 0);
        vecs[21] = mk(1, 0, 0, 0, 0,   0,   0,   0, 0,     0, 0, 0);
        vecs[22] = mk(0, 1, 3, 0, 0,   0,   0,   0, 0,     1, 3, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 380,  50,   1, 0,     1, 3, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 379,  50,   0, 0,     1, 3, 0);
        vecs[25] = mk(1, 0, 0, 0, 0,   0,   0,   0, 0,     0, 0, 0);
        vecs[26] = mk(0, 1, 7, 0, 0,   0,   0,   0, 0,     1, 7, 0);
        vecs[27] = mk(0, 0, 0, 0, 0,  90, 310,   1, 0,     1, 7, 0);
        vecs[28] = mk(0, 0, 0, 0, 0,  91, 311,   1, 161,   1, 7, 0);

        for (int i = 0; i < NV; i++) begin
            drive(int'(vecs[i].rst), int'(vecs[i].spawn), int'(vecs[i].pos), int'(vecs[i].hit),
                  int'(vecs[i].tick), int'(vecs[i].h), int'(vecs[i].v));
            chk_all($sformatf("vec%0d", i), int'(vecs[i].e_draw), int'(vecs[i].e_addr),
                    int'(vecs[i].e_act), int'(vecs[i].e_pos), int'(vecs[i].e_done));
        end

        // Hit blink: visible frames 0-3 and 8-11, despawn pulse on 16th tick
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 5, 0, 0, 235, 180);
        drive(0, 0, 0, 1, 0, 235, 180);
        chk("hit entry draw_en", int'(draw_en), 1);
        for (int f = 0; f < 16; f++) begin
            drive(0, 0, 0, (f == 5) ? 1 : 0, 0, 236, 181);
            chk($sformatf("blink f%0d draw_en", f), int'(draw_en), ((f / 4) % 2 == 0) ? 1 : 0);
            chk($sformatf("blink f%0d rom_addr", f), int'(rom_addr), ((f / 4) % 2 == 0) ? 161 : 0);
            drive(0, 0, 0, 0, 1, 236, 181);
            chk($sformatf("tick f%0d hit_done", f), int'(hit_done), (f == 15) ? 1 : 0);
            chk($sformatf("tick f%0d active", f), int'(active), (f == 15) ? 0 : 1);
        end
        chk("despawn cur_pos", int'(cur_pos), 0);
        drive(0, 0, 0, 0, 0, 236, 181);
        chk_all("post despawn", 0, 0, 0, 0, 0);

        // Reset on the would-be final HIT tick suppresses hit_done
        drive(0, 1, 5, 0, 0, 235, 180);
        drive(0, 0, 0, 1, 0, 235, 180);
        for (int f = 0; f < 15; f++) drive(0, 0, 0, 0, 1, 235, 180);
        chk("timer15 active", int'(active), 1);
        drive(1, 0, 0, 0, 1, 235, 180);
        chk_all("rst mid-hit", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 235, 180);
        chk_all("after rst", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
